// File: rtl/adder_sequencer.sv
// adder_sequencer: limb-serial multi-word adder (one 8-bit adder, one limb per clock).
// Ports: clock/resetN (async active-low), reqValid/reqReady + a/b/carryIn request,
//        rspValid/rspReady + sum/carryOut response, busy (ADD or DONE).
// Option: define ADDER_SEQ_SUB_EN to add input sub; sub=1 computes a + ~b + 1
//         (carryIn ignored) and carryOut=1 means no borrow.
module adder8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  output logic [7:0] o_s,
  output logic       o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_c};
endmodule

module adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  input  logic               carryIn,
`ifdef ADDER_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               rspValid,
  input  logic               rspReady,
  output logic [8*WORDS-1:0] sum,
  output logic               carryOut,
  output logic               busy
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t             r_state, w_next;
  logic [8*WORDS-1:0] r_a, r_b, r_sum;
  logic [IW-1:0]      r_idx;
  logic               r_carry, r_cout;
  logic [7:0]         w_a_limb, w_b_limb, w_b_op, w_s;
  logic               w_c, w_last, w_accept, w_cin;
`ifdef ADDER_SEQ_SUB_EN
  logic r_sub;
  assign w_b_op = r_sub ? ~w_b_limb : w_b_limb;
  // subtraction seeds the carry chain with 1 to form the two's complement of b
  assign w_cin  = sub | carryIn;
`else
  assign w_b_op = w_b_limb;
  assign w_cin  = carryIn;
`endif
  assign w_last   = r_idx == IW'(WORDS - 1);
  assign w_accept = reqValid && reqReady;
  always_comb begin
    w_a_limb = '0;
    w_b_limb = '0;
    for (int i = 0; i < WORDS; i++)
      if (r_idx == IW'(i)) begin
        w_a_limb = r_a[8*i +: 8];
        w_b_limb = r_b[8*i +: 8];
      end
  end
  adder8 u_add (.i_a(w_a_limb), .i_b(w_b_op), .i_c(r_carry), .o_s(w_s), .o_c(w_c));
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (reqValid ? ADD : IDLE) :
             (r_state == ADD)  ? (w_last ? DONE : ADD) :
             (r_state == DONE) ? (rspReady ? IDLE : DONE) : IDLE;
  always_comb begin
    reqReady = r_state == IDLE;
    rspValid = r_state == DONE;
    busy     = (r_state == ADD) || (r_state == DONE);
  end
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_idx   <= '0;
      r_carry <= w_cin;
`ifdef ADDER_SEQ_SUB_EN
      r_sub   <= sub;
`endif
    end else if (r_state == ADD) begin
      for (int i = 0; i < WORDS; i++)
        if (r_idx == IW'(i)) r_sum[8*i +: 8] <= w_s;
      r_carry <= w_c;
      r_idx   <= r_idx + IW'(1);
      if (w_last) r_cout <= w_c;
    end
  assign sum      = r_sum;
  assign carryOut = r_cout;
endmodule

// File: tb/tb_adder_sequencer.sv
// tb_adder_sequencer: randomized and directed checks of adder_sequencer against an arithmetic model.
module tb_adder_sequencer;
  localparam int W = 4;
  logic clock = 1'b0, resetN = 1'b0, reqValid = 1'b0, rspReady = 1'b0, carryIn = 1'b0;
  logic [8*W-1:0] a = '0, b = '0, sum;
  logic reqReady, rspValid, carryOut, busy;
`ifdef ADDER_SEQ_SUB_EN
  logic sub = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;
  adder_sequencer #(.WORDS(W)) dut (
    .clock(clock), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
    .a(a), .b(b), .carryIn(carryIn),
`ifdef ADDER_SEQ_SUB_EN
    .sub(sub),
`endif
    .rspValid(rspValid), .rspReady(rspReady), .sum(sum), .carryOut(carryOut), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic cin, input logic s,
                     input int hold);
    logic [32:0] full;
    logic [31:0] held;
    int cnt;
    full = s ? {1'b0, x} + {1'b0, ~y} + 33'd1 : {1'b0, x} + {1'b0, y} + {32'd0, cin};
    @(negedge clock);
    check("idle_ready", reqReady, 1);
    reqValid = 1; a = x; b = y; carryIn = cin; rspReady = 0;
`ifdef ADDER_SEQ_SUB_EN
    sub = s;
`endif
    @(posedge clock); #1;
    reqValid = $urandom_range(0, 1);
    a = $urandom; b = $urandom; carryIn = $urandom_range(0, 1);
    cnt = 0;
    while (!rspValid && cnt < 20) begin
      check("busy_add", {busy, reqReady}, 2'b10);
      @(posedge clock); #1;
      cnt++;
    end
    check("latency", cnt, W);
    check("sum", sum, full[31:0]);
    check("carry", carryOut, full[32]);
    held = sum;
    for (int i = 0; i < hold; i++) begin
      reqValid = 1; a = $urandom; b = $urandom;
      @(posedge clock); #1;
      check("hold_valid", {rspValid, reqReady, busy}, 3'b101);
      check("hold_sum", sum, held);
    end
    reqValid = 0; rspReady = 1;
    @(posedge clock); #1;
    check("consumed", {rspValid, reqReady, busy}, 3'b010);
    rspReady = 0;
  endtask
  initial begin
    #12;
    check("rst_out", {sum, carryOut, rspValid, busy}, '0);
    @(negedge clock); resetN = 1;
    @(negedge clock);
    check("rst_ready", reqReady, 1);
    run(32'd57, 32'd78, 0, 0, 0);
    run(32'hFFFFFFFF, 32'h1, 0, 0, 0);
    run(32'hE8, 32'h29, 1, 0, 3);
    @(negedge clock);
    reqValid = 1; a = 32'h12345678; b = 32'h9ABCDEF0; carryIn = 1;
    @(posedge clock); #1;
    reqValid = 0;
    @(posedge clock); @(posedge clock); #1;
    check("mid_busy", busy, 1);
    resetN = 0; #1;
    check("abort_out", {sum, carryOut, rspValid, busy}, '0);
    @(negedge clock); resetN = 1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clock); #1;
      check("no_rsp", {rspValid, reqReady}, 2'b01);
    end
    run(32'd12, 32'd104, 1, 0, 0);
`ifdef ADDER_SEQ_SUB_EN
    run(32'h10, 32'h20, 0, 1, 0);
    run(32'h20, 32'h10, 1, 1, 1);
`endif
    for (int i = 0; i < 20; i++)
      run($urandom, (i % 4 == 0) ? ~32'd0 : $urandom, 1'($urandom_range(0, 1)), 0,
          $urandom_range(0, 3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
